// File: rtl/exec_alu_unit_pkg.sv
// Shared encodings for the MIPS32 execute stage: controller classes, funct/shamt
// codes and the internal ALU operation set.
package exec_alu_unit_pkg;

    localparam logic [4:0] AOP_RTYPE    = 5'd0;
    localparam logic [4:0] AOP_ADD      = 5'd1;
    localparam logic [4:0] AOP_SUB      = 5'd2;
    localparam logic [4:0] AOP_ANDI     = 5'd3;
    localparam logic [4:0] AOP_ORI      = 5'd4;
    localparam logic [4:0] AOP_XORI     = 5'd5;
    localparam logic [4:0] AOP_SLTI     = 5'd6;
    localparam logic [4:0] AOP_SLTIU    = 5'd7;
    localparam logic [4:0] AOP_LUI      = 5'd8;
    localparam logic [4:0] AOP_SPECIAL2 = 5'd9;
    localparam logic [4:0] AOP_SPECIAL3 = 5'd10;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
    localparam logic [5:0] F_MOVZ = 6'h0A, F_MOVN = 6'h0B;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19;
    localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR = 6'h26, F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;

    localparam logic [5:0] F2_MADD = 6'h00, F2_MUL = 6'h02, F2_MSUB = 6'h04;
    localparam logic [5:0] F3_BSHFL = 6'h20;
    localparam logic [4:0] SA_SEB = 5'h10, SA_SEH = 5'h18;

    // Variable shifts reuse the fixed-shift ops; the datapath picks the amount.
    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
        OP_SLL, OP_SRL, OP_ROTR, OP_SRA,
        OP_MOVZ, OP_MOVN, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
        OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB,
        OP_SEB, OP_SEH, OP_PASSB
    } aluOp_e;

    function automatic logic [31:0] rotr32(input logic [31:0] v, input logic [4:0] s);
        logic [63:0] t;
        t = {v, v} >> s;
        return t[31:0];
    endfunction

endpackage

// File: rtl/exec_alu_unit_alu_control.sv
// Maps the controller class and instruction fields to one internal ALU operation
// and flags the ops that update HI/LO.
module exec_alu_unit_alu_control
    import exec_alu_unit_pkg::*;
(
    input  logic [4:0] aluOp,
    input  logic [5:0] funct,
    input  logic [4:0] shamt,
    input  logic [4:0] rsField,
    output aluOp_e     op,
    output logic       hiloWrite
);

    always_comb begin
        op = OP_ADD;
        case (aluOp)
            AOP_RTYPE: begin
                case (funct)
                    F_SLL, F_SLLV:   op = OP_SLL;
                    F_SRL:           op = rsField[0] ? OP_ROTR : OP_SRL;
                    F_SRLV:          op = shamt[0]   ? OP_ROTR : OP_SRL;
                    F_SRA, F_SRAV:   op = OP_SRA;
                    F_MOVZ:          op = OP_MOVZ;
                    F_MOVN:          op = OP_MOVN;
                    F_MFHI:          op = OP_MFHI;
                    F_MTHI:          op = OP_MTHI;
                    F_MFLO:          op = OP_MFLO;
                    F_MTLO:          op = OP_MTLO;
                    F_MULT:          op = OP_MULT;
                    F_MULTU:         op = OP_MULTU;
                    F_SUB, F_SUBU:   op = OP_SUB;
                    F_AND:           op = OP_AND;
                    F_OR:            op = OP_OR;
                    F_XOR:           op = OP_XOR;
                    F_NOR:           op = OP_NOR;
                    F_SLT:           op = OP_SLT;
                    F_SLTU:          op = OP_SLTU;
                    default:         op = OP_ADD;
                endcase
            end
            AOP_SUB:   op = OP_SUB;
            AOP_ANDI:  op = OP_ANDI;
            AOP_ORI:   op = OP_ORI;
            AOP_XORI:  op = OP_XORI;
            AOP_SLTI:  op = OP_SLT;
            // b arrives already sign-extended, so SLTIU is a plain unsigned compare
            AOP_SLTIU: op = OP_SLTU;
            AOP_LUI:   op = OP_LUI;
            AOP_SPECIAL2: begin
                case (funct)
                    F2_MUL:  op = OP_MUL;
                    F2_MADD: op = OP_MADD;
                    F2_MSUB: op = OP_MSUB;
                    default: op = OP_ADD;
                endcase
            end
            AOP_SPECIAL3: begin
                if (funct == F3_BSHFL && shamt == SA_SEB)      op = OP_SEB;
                else if (funct == F3_BSHFL && shamt == SA_SEH) op = OP_SEH;
                else                                           op = OP_PASSB;
            end
            default:   op = OP_ADD;
        endcase
    end

    assign hiloWrite = op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB, OP_MTHI, OP_MTLO};

endmodule

// File: rtl/exec_alu_unit.sv
// MIPS32 execute stage: combinational ALU, HI/LO multiply registers and the
// branch-target adder.
module exec_alu_unit
    import exec_alu_unit_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [4:0]  rs_field,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] offset,
    output logic [31:0] result,
    output logic        zero,
    output logic        wr_ok,
    output logic [31:0] branch_addr,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    aluOp_e             op;
    logic               hiloWrite;
    logic [4:0]         shAmt;
    logic signed [63:0] aExt, bExt, sProd;
    logic [63:0]        uProd, hiloNext;

    exec_alu_unit_alu_control uCtrl (
        .aluOp     (alu_op),
        .funct     (funct),
        .shamt     (shamt),
        .rsField   (rs_field),
        .op        (op),
        .hiloWrite (hiloWrite)
    );

    // funct[2] distinguishes the variable-amount shift encodings
    assign shAmt = funct[2] ? a[4:0] : shamt;

    assign aExt  = {{32{a[31]}}, a};
    assign bExt  = {{32{b[31]}}, b};
    assign sProd = aExt * bExt;
    assign uProd = {32'b0, a} * {32'b0, b};

    always_comb begin
        result = a + b;
        case (op)
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_NOR:   result = ~(a | b);
            OP_SLT:   result = {31'b0, $signed(a) < $signed(b)};
            OP_SLTU:  result = {31'b0, a < b};
            OP_ANDI:  result = a & {16'b0, b[15:0]};
            OP_ORI:   result = a | {16'b0, b[15:0]};
            OP_XORI:  result = a ^ {16'b0, b[15:0]};
            OP_LUI:   result = {b[15:0], 16'h0};
            OP_SLL:   result = b << shAmt;
            OP_SRL:   result = b >> shAmt;
            OP_ROTR:  result = rotr32(b, shAmt);
            OP_SRA:   result = $signed(b) >>> shAmt;
            OP_MOVZ, OP_MOVN: result = a;
            OP_MFHI:  result = hi;
            OP_MFLO:  result = lo;
            OP_MUL:   result = sProd[31:0];
            OP_SEB:   result = {{24{b[7]}}, b[7:0]};
            OP_SEH:   result = {{16{b[15]}}, b[15:0]};
            OP_PASSB: result = b;
            OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: result = 32'h0;
            default:  result = a + b;
        endcase
    end

    assign zero        = (result == 32'h0);
    assign wr_ok       = (op == OP_MOVZ) ? (b == 32'h0) :
                         (op == OP_MOVN) ? (b != 32'h0) : 1'b1;
    assign branch_addr = pc_plus4 + {offset[29:0], 2'b00};

    always_comb begin
        hiloNext = {hi, lo};
        case (op)
            OP_MULT:  hiloNext = sProd;
            OP_MULTU: hiloNext = uProd;
            OP_MADD:  hiloNext = {hi, lo} + sProd;
            OP_MSUB:  hiloNext = {hi, lo} - sProd;
            OP_MTHI:  hiloNext = {a, lo};
            OP_MTLO:  hiloNext = {hi, a};
            default:  hiloNext = {hi, lo};
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hi <= 32'h0;
            lo <= 32'h0;
        end else if (hiloWrite) begin
            hi <= hiloNext[63:32];
            lo <= hiloNext[31:0];
        end
    end

endmodule

// File: tb/tb_exec_alu_unit.sv
// Directed plus randomized checks of exec_alu_unit against an arithmetic
// reference model of the MIPS32 execute-stage rules.
module tb_exec_alu_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  alu_op, shamt, rs_field;
    logic [5:0]  funct;
    logic [31:0] a, b, pc_plus4, offset;
    logic [31:0] result, branch_addr, hi, lo;
    logic        zero, wr_ok;

    int nCmp = 0;
    int nErr = 0;
    logic [31:0] mHi = 32'h0, mLo = 32'h0;

    exec_alu_unit dut (
        .Clk(Clk), .Reset(Reset), .alu_op(alu_op), .funct(funct), .shamt(shamt),
        .rs_field(rs_field), .a(a), .b(b), .pc_plus4(pc_plus4), .offset(offset),
        .result(result), .zero(zero), .wr_ok(wr_ok), .branch_addr(branch_addr),
        .hi(hi), .lo(lo)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: result, write qualifier, and the new {HI,LO} if the op writes them.
    task automatic refModel(input logic [4:0] op, input logic [5:0] fn, input logic [4:0] sh,
                            input logic [4:0] rsf, input logic [31:0] av, input logic [31:0] bv,
                            output logic [31:0] r, output logic w, output logic hw,
                            output logic [63:0] hl);
        longint      sa, sb, sp;
        logic [63:0] rot, up;
        int          amt;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        sp = sa * sb;
        up = 64'(av) * 64'(bv);
        r  = av + bv;
        w  = 1'b1;
        hw = 1'b0;
        hl = {mHi, mLo};
        amt = fn[2] ? int'(av[4:0]) : int'(sh);
        rot = {bv, bv} >> amt;
        case (op)
            5'd0: case (fn)
                6'h00, 6'h04: r = bv << amt;
                6'h02: r = rsf[0] ? rot[31:0] : bv >> amt;
                6'h06: r = sh[0]  ? rot[31:0] : bv >> amt;
                6'h03, 6'h07: r = 32'(sb >>> amt);
                6'h0A: begin r = av; w = (bv == 0); end
                6'h0B: begin r = av; w = (bv != 0); end
                6'h10: r = mHi;
                6'h12: r = mLo;
                6'h11: begin r = 0; hw = 1; hl = {av, mLo}; end
                6'h13: begin r = 0; hw = 1; hl = {mHi, av}; end
                6'h18: begin r = 0; hw = 1; hl = 64'(sp); end
                6'h19: begin r = 0; hw = 1; hl = up; end
                6'h22, 6'h23: r = av - bv;
                6'h24: r = av & bv;
                6'h25: r = av | bv;
                6'h26: r = av ^ bv;
                6'h27: r = ~(av | bv);
                6'h2A: r = (sa < sb) ? 1 : 0;
                6'h2B: r = (av < bv) ? 1 : 0;
                default: r = av + bv;
            endcase
            5'd2: r = av - bv;
            5'd3: r = av & (bv % 65536);
            5'd4: r = av | (bv % 65536);
            5'd5: r = av ^ (bv % 65536);
            5'd6: r = (sa < sb) ? 1 : 0;
            5'd7: r = (av < bv) ? 1 : 0;
            5'd8: r = bv * 65536;
            5'd9: case (fn)
                6'h02: r = 32'(sp);
                6'h00: begin r = 0; hw = 1; hl = {mHi, mLo} + 64'(sp); end
                6'h04: begin r = 0; hw = 1; hl = {mHi, mLo} - 64'(sp); end
                default: r = av + bv;
            endcase
            5'd10: begin
                if (fn == 6'h20 && sh == 5'h10)      r = 32'(longint'($signed(bv[7:0])));
                else if (fn == 6'h20 && sh == 5'h18) r = 32'(longint'($signed(bv[15:0])));
                else                                 r = bv;
            end
            default: r = av + bv;
        endcase
    endtask

    task automatic step(input logic [4:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [4:0] rsf, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] pc, input logic [31:0] off);
        logic [31:0] er;
        logic        ew, ehw;
        logic [63:0] ehl;
        alu_op = op; funct = fn; shamt = sh; rs_field = rsf;
        a = av; b = bv; pc_plus4 = pc; offset = off;
        #1;
        refModel(op, fn, sh, rsf, av, bv, er, ew, ehw, ehl);
        chk("result", result, er);
        chk("zero", {31'b0, zero}, {31'b0, er == 32'h0});
        chk("wr_ok", {31'b0, wr_ok}, {31'b0, ew});
        chk("branch_addr", branch_addr, pc + off * 4);
        @(posedge Clk);
        if (Reset) {mHi, mLo} = 64'h0;
        else if (ehw) {mHi, mLo} = ehl;
        #1;
        chk("hi", hi, mHi);
        chk("lo", lo, mLo);
    endtask

    logic [5:0] rFuncts [26] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0A, 6'h0B,
                                 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h20, 6'h21,
                                 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                                 6'h01, 6'h3F};

    initial begin
        Reset = 1'b1;
        step(5'd0, 6'h10, 5'd0, 5'd0, 32'h1111, 32'h2222, 32'h0, 32'h0);
        chk("reset_mfhi", result, 32'h0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        // write attempted while Reset is held must be ignored
        step(5'd0, 6'h11, 5'd0, 5'd0, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0);
        chk("reset_prio_hi", hi, 32'h0);
        Reset = 1'b0;

        step(5'd0, 6'h11, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
        chk("mthi", hi, 32'hDEADBEEF);
        step(5'd0, 6'h18, 5'd0, 5'd0, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
        step(5'd0, 6'h10, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("mfhi_after_mult", result, 32'hFFFFFFFF);
        step(5'd9, 6'h00, 5'd0, 5'd0, 32'd2, 32'd3, 32'h0, 32'h0);
        chk("madd_hi", hi, 32'h0);
        chk("madd_lo", lo, 32'h0);

        step(5'd0, 6'h2B, 5'd0, 5'd0, 32'd1, 32'hFFFFFFFF, 32'h0, 32'h0);
        chk("sltu", result, 32'd1);
        step(5'd0, 6'h2A, 5'd0, 5'd0, 32'd1, 32'hFFFFFFFF, 32'h0, 32'h0);
        chk("slt", result, 32'd0);
        step(5'd0, 6'h02, 5'd4, 5'd1, 32'h0, 32'h12345678, 32'h0, 32'h0);
        chk("rotr", result, 32'h81234567);
        step(5'd0, 6'h02, 5'd4, 5'd0, 32'h0, 32'h12345678, 32'h0, 32'h0);
        chk("srl", result, 32'h01234567);
        step(5'd0, 6'h0B, 5'd0, 5'd0, 32'd5, 32'd0, 32'h0, 32'h0);
        chk("movn_b0", {31'b0, wr_ok}, 32'd0);
        step(5'd0, 6'h0B, 5'd0, 5'd0, 32'd5, 32'd7, 32'h0, 32'h0);
        chk("movn_b7_wr", {31'b0, wr_ok}, 32'd1);
        chk("movn_b7_res", result, 32'd5);
        step(5'd2, 6'h00, 5'd0, 5'd0, 32'd9, 32'd9, 32'h0, 32'h0);
        chk("beq_zero", {31'b0, zero}, 32'd1);
        step(5'd10, 6'h20, 5'h10, 5'd0, 32'h0, 32'h00000080, 32'h100, 32'hFFFFFFFF);
        chk("seb", result, 32'hFFFFFF80);
        chk("branch_neg", branch_addr, 32'h000000FC);

        step(5'd0, 6'h13, 5'd0, 5'd0, 32'h0BADF00D, 32'h0, 32'h0, 32'h0);
        // asynchronous reset away from any clock edge
        #2 Reset = 1'b1;
        #1;
        chk("async_reset_lo", lo, 32'h0);
        mHi = 32'h0; mLo = 32'h0;
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            logic [4:0] op;
            logic [5:0] fn;
            logic [4:0] sh;
            op = 5'($urandom_range(0, 15));
            fn = 6'($urandom);
            sh = 5'($urandom);
            if (op == 5'd0) fn = rFuncts[$urandom_range(0, 25)];
            if (op == 5'd9) fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(2 * $urandom_range(0, 2));
            if (op == 5'd10) begin
                fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'h20;
                case ($urandom_range(0, 2))
                    0: sh = 5'h10;
                    1: sh = 5'h18;
                    default: ;
                endcase
            end
            step(op, fn, sh, 5'($urandom), $urandom,
                 ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom, $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
